// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline registers.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    // Canonical RV32I NOP (addi x0, x0, 0) loaded by the bubble logic.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the E-stage load writes a register the C-stage instruction reads.
module hazard_detect (
    input  logic [4:0] rs1C,
    input  logic [4:0] rs2C,
    input  logic       use_rs1C,
    input  logic       use_rs2C,
    input  logic [4:0] rdE,
    input  logic       is_loadE,
    output logic       lu
);

    // x0 is never a real dependency, so a load into x0 never stalls.
    always_comb begin
        lu = is_loadE && (rdE != 5'd0) &&
             ((use_rs1C && (rs1C == rdE)) || (use_rs2C && (rs2C == rdE)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/bubble/flush generation, dmem wait with timeout,
// halt/drain/resume sequencing and a stall-cycle performance counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [4:0]  rs1C,
    input  logic [4:0]  rs2C,
    input  logic        use_rs1C,
    input  logic        use_rs2C,
    input  logic [4:0]  rdE,
    input  logic        is_loadE,
    input  logic        fail_predict,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        stallF,
    output logic        stallC,
    output logic        flushC,
    output logic        bubbleE,
    output logic        freeze,
    output logic        bubbleW,
    output logic        halted,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT) + 1;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [2:0]    dcnt;
    logic          lu;
    logic          mw;
    logic          timeout;

    hazard_detect u_detect (
        .rs1C     (rs1C),
        .rs2C     (rs2C),
        .use_rs1C (use_rs1C),
        .use_rs2C (use_rs2C),
        .rdE      (rdE),
        .is_loadE (is_loadE),
        .lu       (lu)
    );

    // A dmem access still waiting this cycle, and the forced release once it has waited too long.
    always_comb begin
        mw      = dmem_req && !dmem_ready;
        timeout = (state == MEM_WAIT) && mw && (tcnt == TW'(MEM_TIMEOUT - 1));
    end

    // Control outputs: memory freeze beats mispredict flush beats load-use stall.
    always_comb begin
        stallF  = 1'b0;
        stallC  = 1'b0;
        flushC  = 1'b0;
        bubbleE = 1'b0;
        freeze  = 1'b0;
        bubbleW = 1'b0;
        halted  = 1'b0;
        mem_err = timeout;
        case (state)
            RUN, MEM_WAIT: begin
                if (mw && !timeout) begin
                    stallF  = 1'b1;
                    stallC  = 1'b1;
                    freeze  = 1'b1;
                    bubbleW = 1'b1;
                end else if (fail_predict) begin
                    flushC  = 1'b1;
                    bubbleE = 1'b1;
                end else if (lu) begin
                    stallF  = 1'b1;
                    stallC  = 1'b1;
                    bubbleE = 1'b1;
                end
            end
            DRAIN: begin
                if (mw) begin
                    stallF  = 1'b1;
                    stallC  = 1'b1;
                    freeze  = 1'b1;
                    bubbleW = 1'b1;
                end else begin
                    stallF  = 1'b1;
                    flushC  = 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
                stallF = 1'b1;
                flushC = 1'b1;
            end
            default: begin
                stallF = 1'b0;
            end
        endcase
    end

    // Sequencer state, wait/drain counters and the stall-cycle counter.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state     <= RUN;
            tcnt      <= '0;
            dcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            if (stallF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            case (state)
                RUN: begin
                    if (mw) begin
                        state <= MEM_WAIT;
                        tcnt  <= TW'(1);
                    end else if (halt_req) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mw || timeout) begin
                        state <= RUN;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!mw) begin
                        if (dcnt == 3'(DRAIN_CYCLES - 1)) begin
                            state <= HALTED;
                            dcnt  <= '0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl with hand-written multi-cycle sequences.
module tb_hazard_ctrl;

    // Expected control patterns: {stallF,stallC,flushC,bubbleE,freeze,bubbleW,halted,mem_err}
    localparam logic [7:0] E_IDLE = 8'b0000_0000;
    localparam logic [7:0] E_LU   = 8'b1101_0000;
    localparam logic [7:0] E_FP   = 8'b0011_0000;
    localparam logic [7:0] E_FRZ  = 8'b1100_1100;
    localparam logic [7:0] E_DRN  = 8'b1010_0000;
    localparam logic [7:0] E_HLT  = 8'b1010_0010;
    localparam logic [7:0] E_TMO  = 8'b0000_0001;

    typedef struct {
        string       name;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        ld;
        logic        fp;
        logic        req;
        logic        rdy;
        logic        hreq;
        logic        res;
        logic [7:0]  exp;
        logic [31:0] cnt;
    } vec_t;

    logic        CLK;
    logic        NRST;
    logic [4:0]  rs1C;
    logic [4:0]  rs2C;
    logic        use_rs1C;
    logic        use_rs2C;
    logic [4:0]  rdE;
    logic        is_loadE;
    logic        fail_predict;
    logic        dmem_req;
    logic        dmem_ready;
    logic        halt_req;
    logic        resume;
    logic        stallF;
    logic        stallC;
    logic        flushC;
    logic        bubbleE;
    logic        freeze;
    logic        bubbleW;
    logic        halted;
    logic        mem_err;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    hazard_ctrl #(
        .MEM_TIMEOUT  (8),
        .DRAIN_CYCLES (3)
    ) dut (
        .CLK          (CLK),
        .NRST         (NRST),
        .rs1C         (rs1C),
        .rs2C         (rs2C),
        .use_rs1C     (use_rs1C),
        .use_rs2C     (use_rs2C),
        .rdE          (rdE),
        .is_loadE     (is_loadE),
        .fail_predict (fail_predict),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .resume       (resume),
        .stallF       (stallF),
        .stallC       (stallC),
        .flushC       (flushC),
        .bubbleE      (bubbleE),
        .freeze       (freeze),
        .bubbleW      (bubbleW),
        .halted       (halted),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkv(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                 logic [4:0] rd, logic ld, logic fp, logic req, logic rdy,
                                 logic hreq, logic res, logic [7:0] e, logic [31:0] c);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld;
        v.fp = fp; v.req = req; v.rdy = rdy; v.hreq = hreq; v.res = res; v.exp = e; v.cnt = c;
        return v;
    endfunction

    function automatic vec_t idle(string n, logic req, logic rdy, logic hreq, logic res,
                                  logic [7:0] e, logic [31:0] c);
        return mkv(n, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, req, rdy, hreq, res, e, c);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rs1C = v.rs1; rs2C = v.rs2; use_rs1C = v.u1; use_rs2C = v.u2; rdE = v.rd;
        is_loadE = v.ld; fail_predict = v.fp; dmem_req = v.req; dmem_ready = v.rdy;
        halt_req = v.hreq; resume = v.res;
    endtask

    task automatic checkOutput(input string n, input logic [7:0] e, input logic [31:0] c);
        logic [7:0] got;
        got = {stallF, stallC, flushC, bubbleE, freeze, bubbleW, halted, mem_err};
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL %s ctl got=%b want=%b", n, got, e);
        end
        total++;
        if (stall_cnt !== c) begin
            bad++;
            $display("[TB] FAIL %s stall_cnt got=%0d want=%0d", n, stall_cnt, c);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(negedge CLK);
        checkOutput(v.name, v.exp, v.cnt);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Table: single-cycle hazards, a 4-cycle memory wait and coincident events.
        tbl.push_back(idle("idle0", 0, 0, 0, 0, E_IDLE, 0));
        tbl.push_back(mkv("lu_rs1", 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, E_LU, 0));
        tbl.push_back(idle("lu_one_cycle", 0, 0, 0, 0, E_IDLE, 1));
        tbl.push_back(mkv("lu_rd0", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, E_IDLE, 1));
        tbl.push_back(mkv("lu_rs2", 7, 7, 0, 1, 7, 1, 0, 0, 0, 0, 0, E_LU, 1));
        tbl.push_back(mkv("lu_nouse", 9, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, E_IDLE, 2));
        tbl.push_back(mkv("lu_noload", 9, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0, E_IDLE, 2));
        tbl.push_back(mkv("mispredict", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_FP, 2));
        tbl.push_back(mkv("fp_over_lu", 3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, E_FP, 2));
        tbl.push_back(idle("mw1", 1, 0, 0, 0, E_FRZ, 2));
        tbl.push_back(idle("mw2", 1, 0, 0, 0, E_FRZ, 3));
        tbl.push_back(idle("mw3", 1, 0, 0, 0, E_FRZ, 4));
        tbl.push_back(idle("mw4", 1, 0, 0, 0, E_FRZ, 5));
        tbl.push_back(idle("mw_ready", 1, 1, 0, 0, E_IDLE, 6));
        tbl.push_back(idle("mw_after", 0, 0, 0, 0, E_IDLE, 6));
        tbl.push_back(mkv("all3_a", 3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 0, E_FRZ, 6));
        tbl.push_back(mkv("all3_b", 3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 0, E_FRZ, 7));
        tbl.push_back(mkv("all3_ready", 3, 0, 1, 0, 3, 1, 1, 1, 1, 0, 0, E_FP, 8));
        tbl.push_back(idle("all3_after", 0, 0, 0, 0, E_IDLE, 8));
        tbl.push_back(idle("req_drop_a", 1, 0, 0, 0, E_FRZ, 8));
        tbl.push_back(mkv("req_drop_lu", 4, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, E_LU, 9));
        tbl.push_back(idle("req_drop_after", 0, 0, 0, 0, E_IDLE, 10));

        NRST = 1'b0;
        applyStimulus(idle("init", 0, 0, 0, 0, E_IDLE, 0));
        #12;
        checkOutput("reset", E_IDLE, 0);
        NRST = 1'b1;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) runVec(tbl[i]);

        // Timeout: the 8th consecutive wait cycle releases with mem_err.
        for (int i = 1; i <= 8; i++) begin
            runVec(idle("timeout", 1, 0, 0, 0, (i == 8) ? E_TMO : E_FRZ, 32'(10 + i - 1)));
        end
        runVec(idle("timeout_rewait", 1, 0, 0, 0, E_FRZ, 17));
        runVec(idle("timeout_drop", 0, 0, 0, 0, E_IDLE, 18));

        // Halt pulse, drain, halted, resume.
        runVec(idle("halt_req", 0, 0, 1, 0, E_IDLE, 18));
        runVec(idle("drain1", 0, 0, 0, 0, E_DRN, 18));
        runVec(idle("drain2", 0, 0, 0, 0, E_DRN, 19));
        runVec(idle("drain3", 0, 0, 0, 0, E_DRN, 20));
        runVec(idle("halted_ignore_req", 0, 0, 1, 0, E_HLT, 21));
        runVec(idle("halted_resume", 0, 0, 0, 1, E_HLT, 22));
        runVec(idle("resumed", 0, 0, 0, 0, E_IDLE, 23));

        // Memory wait during drain holds the drain counter.
        runVec(idle("halt_req2", 0, 0, 1, 0, E_IDLE, 23));
        runVec(idle("drain_mw", 1, 0, 0, 0, E_FRZ, 23));
        runVec(idle("drain_b1", 0, 0, 0, 0, E_DRN, 24));
        runVec(idle("drain_b2", 0, 0, 0, 0, E_DRN, 25));
        runVec(idle("drain_b3", 0, 0, 0, 0, E_DRN, 26));
        runVec(idle("halted2", 0, 0, 0, 1, E_HLT, 27));
        runVec(idle("resumed2", 0, 0, 0, 0, E_IDLE, 28));

        // Async reset in the middle of a wait with the counter at 5.
        for (int i = 1; i <= 5; i++) begin
            runVec(idle("pre_reset_wait", 1, 0, 0, 0, E_FRZ, 32'(28 + i - 1)));
        end
        applyStimulus(idle("rst", 0, 0, 0, 0, E_IDLE, 0));
        NRST = 1'b0;
        #2;
        checkOutput("async_reset", E_IDLE, 0);
        @(posedge CLK);
        #1;
        checkOutput("reset_held", E_IDLE, 0);
        NRST = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 1; i <= 8; i++) begin
            runVec(idle("fresh_wait", 1, 0, 0, 0, (i == 8) ? E_TMO : E_FRZ, 32'(i - 1)));
        end
        runVec(idle("final_idle", 0, 0, 0, 0, E_IDLE, 7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (F, C, E, M, W). It generates the stall, bubble and flush controls for every inter-stage register, including fc_reg's stall and fail_predict inputs. It handles load-use hazards, data-memory wait states with a timeout, branch-mispredict flushes, and a halt/drain/resume sequence. It also keeps a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 64, max consecutive wait cycles on a dmem access before forced release (>=2)
DRAIN_CYCLES, 3, cycles after fetch stop until pipeline is empty (1..7)

Ports:
CLK  in  1  clock, rising edge
NRST  in  1  reset, asynchronous, active-low
rs1C  in  5  source reg 1 of instruction in C stage
rs2C  in  5  source reg 2 of instruction in C stage
use_rs1C  in  1  C-stage instruction reads rs1
use_rs2C  in  1  C-stage instruction reads rs2
rdE  in  5  dest reg of instruction in E stage
is_loadE  in  1  E-stage instruction is a load
fail_predict  in  1  E-stage branch resolved as mispredicted
dmem_req  in  1  M stage has an outstanding dmem access
dmem_ready  in  1  dmem completes the access this cycle
halt_req  in  1  halt request (level)
resume  in  1  leave HALTED (pulse)
stallF  out  1  hold PC
stallC  out  1  hold fc register (fc_reg stall)
flushC  out  1  clear fc register (fc_reg fail_predict)
bubbleE  out  1  load NOP into C/E register
freeze  out  1  hold C/E and E/M registers
bubbleW  out  1  load NOP into M/W register
halted  out  1  core halted
mem_err  out  1  one-cycle pulse on dmem timeout
stall_cnt  out  32  count of cycles with stallF=1

Behaviour:
- Interface: single clock CLK. NRST is asynchronous and active-low. All state resets immediately on NRST low.
- Reset values: state=RUN, timeout counter=0, drain counter=0, stall_cnt=0, mem_err=0, halted=0.
- Control outputs are combinational from registered state and current inputs. With idle inputs in RUN, every control output is 0.
- Hazard terms:
  - lu = is_loadE & rdE!=0 & ((use_rs1C & rs1C==rdE) | (use_rs2C & rs2C==rdE)).
  - mw = dmem_req & ~dmem_ready.
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
- Priority within RUN/MEM_WAIT: memory wait > mispredict > load-use.
- Memory-wait condition (mw=1 in RUN, or in MEM_WAIT):
  - Outputs: stallF=stallC=freeze=bubbleW=1; flushC=bubbleE=0. A pending fail_predict is suppressed while frozen; E holds, so it reasserts after release.
  - Counter: RUN->MEM_WAIT loads the timeout counter with 1. Each MEM_WAIT cycle with mw=1 increments it.
- MEM_WAIT exits:
  - dmem_ready=1 -> RUN. Outputs that cycle are as in RUN with mw=0.
  - Counter reaches MEM_TIMEOUT-1 while mw=1 -> mem_err=1 for that cycle. Freeze drops that cycle and the state returns to RUN.
  - dmem_req deasserted -> RUN, no error.
- Mispredict (fail_predict=1, mw=0): flushC=1 and bubbleE=1; stallF=stallC=0. PC loads the branch target, steered externally.
- Load-use (lu=1, mw=0, fail_predict=0): stallF=stallC=1 and bubbleE=1 for exactly one cycle. Next cycle the load is in M and lu clears naturally. No FSM state is used.
- Halt:
  - halt_req sampled in RUN when mw=0 -> DRAIN, drain counter=0.
  - DRAIN: stallF=1, flushC=1 (no new instructions enter), E/M/W proceed.
  - mw=1 during DRAIN: freeze/bubbleW as above, and the drain counter holds.
  - Drain counter reaching DRAIN_CYCLES-1 -> HALTED.
- HALTED: halted=1, stallF=1, flushC=1; other controls 0. resume=1 -> RUN next cycle. halt_req is ignored in HALTED.
- halt_req deasserted during DRAIN: drain still completes to HALTED.
- stall_cnt increments every cycle stallF=1, including DRAIN and HALTED. It wraps 0xFFFFFFFF->0.
- NRST asserted mid-operation (MEM_WAIT, DRAIN): immediate return to RUN with all counters cleared. A mem_err pulse in flight is dropped.

Decomposition:
- Shared package hazard_pkg: state encoding constants (RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3) and a NOP instruction constant (32'h00000013) used by the bubble logic in the pipeline registers.
- One sub-module is natural: hazard_detect, purely combinational, computing lu from the rs/rd fields. The FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use: is_loadE=1, rdE=5, rs1C=5, use_rs1C=1 for one cycle -> stallF=stallC=bubbleE=1 that cycle only; stall_cnt=1. Repeat with rdE=0 -> no stall.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles then ready=1 -> freeze=bubbleW=stallF=1 for exactly 4 cycles, RUN on the 5th; stall_cnt=4.
- Timeout: MEM_TIMEOUT=8, dmem_req=1, dmem_ready never -> mem_err=1 on the 8th wait cycle; freeze=0 that cycle and the state is RUN.
- Simultaneous events: fail_predict=1 together with mw=1 and lu=1 -> freeze only, no flushC. After ready -> flushC=bubbleE=1, and no load-use stall that cycle.
- Halt/resume: halt_req pulse, DRAIN_CYCLES=3 -> halted=1 on the 4th cycle after the request. resume pulse -> halted=0 next cycle, stallF=0.
- Async reset: NRST low mid-MEM_WAIT with counter=5 -> all outputs 0 before the next CLK edge; after release, a fresh wait starts the counter from 1.
